fir_par3_serializer: RTL and testbench

- Output-side companion of the 3-parallel (L=3) FIR filter.
- Accepts one block of three parallel output samples per handshake: data1 = y(3k), data2 = y(3k+1), data3 = y(3k+2).
- Re-emits the samples as a single serial stream, one sample per accepted output beat, in time order.
- Holds up to FIFO_DEPTH blocks so the filter can keep running while the serial consumer stalls.

---
 rtl/fir_par3_serializer.sv | 145 ++++++++++++++
 tb/tb_fir_par3_serializer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_par3_serializer.sv
// Serializer behind the 3-parallel FIR: buffers blocks of (y(3k), y(3k+1), y(3k+2)) and emits them one per beat.
// Optional stall statistics port enabled by defining FIR_SER_STALL_STATS_EN.
module fir_par3_serializer #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data1,
  input  logic [DATA_WIDTH-1:0] in_data2,
  input  logic [DATA_WIDTH-1:0] in_data3,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            out_phase,
  output logic                  out_last
`ifdef FIR_SER_STALL_STATS_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    P0 = 2'd0,
    P1 = 2'd1,
    P2 = 2'd2
  } phase_t;

  phase_t             phase_reg, phase_next;
  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [PTR_W:0]     count_reg, count_next;

  logic               push;
  logic               xfer;
  logic               pop;

  logic [DATA_WIDTH-1:0] in_lane   [3];
  logic [DATA_WIDTH-1:0] head_lane [3];

  assign in_lane[0] = in_data1;
  assign in_lane[1] = in_data2;
  assign in_lane[2] = in_data3;

  // in_ready deliberately ignores the same-cycle pop so out_ready never reaches in_ready.
  assign in_ready  = !reset && (count_reg < DEPTH_C);
  assign out_valid = !reset && (count_reg != '0);
  assign push      = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign pop       = xfer && (phase_reg == P2);

  // One storage array per lane; the head entry is read straight from the registers.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

      always_ff @(posedge clk) begin
        if (push) begin
          mem[wr_ptr_reg] <= in_lane[gi];
        end
      end

      assign head_lane[gi] = mem[rd_ptr_reg];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_reg  <= P0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      phase_reg  <= phase_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  always_comb begin
    phase_next = phase_reg;
    if (xfer) begin
      case (phase_reg)
        P0:      phase_next = P1;
        P1:      phase_next = P2;
        default: phase_next = P0;
      endcase
    end
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_comb begin
    out_data  = '0;
    out_phase = 2'd0;
    if (out_valid) begin
      out_phase = phase_reg;
      case (phase_reg)
        P0:      out_data = head_lane[0];
        P1:      out_data = head_lane[1];
        default: out_data = head_lane[2];
      endcase
    end
  end

  assign out_last = (out_phase == 2'd2);

`ifdef FIR_SER_STALL_STATS_EN
  logic [15:0] stall_cnt_reg;

  // Counts cycles where upstream offers a block that the full buffer refuses.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg <= 16'd0;
    end else if (in_valid && !in_ready && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_fir_par3_serializer.sv
// Directed bench for fir_par3_serializer: reset, single block, streaming, backpressure, signed data, mid-block reset.
module tb_fir_par3_serializer;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data1, in_data2, in_data3;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    out_phase;
  logic          out_last;
`ifdef FIR_SER_STALL_STATS_EN
  logic [15:0]   stall_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fir_par3_serializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data1 (in_data1),
    .in_data2 (in_data2),
    .in_data3 (in_data3),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_phase(out_phase),
    .out_last (out_last)
`ifdef FIR_SER_STALL_STATS_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_block(input int a, input int b, input int c);
    in_data1 = DW'(a);
    in_data2 = DW'(b);
    in_data3 = DW'(c);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    set_block(7, 8, 9);
    repeat (3) tick();
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    tests++; if (out_data !== '0) begin fails++; $display("FAIL reset_out_data got %0h exp 0", out_data); end
    tests++; if (out_phase !== 2'd0 || out_last !== 1'b0) begin fails++; $display("FAIL reset_phase_last got %0d/%b exp 0/0", out_phase, out_last); end
    in_valid = 1'b0; reset = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL post_reset_out_valid got %b exp 0", out_valid); end
    $display("[TB] reset done");
  endtask

  task automatic test_single();
    logic [DW-1:0] e;
    out_ready = 1'b1; in_valid = 1'b1;
    set_block(1, 2, 3);
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL single_in_ready got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e = DW'(i + 1);
      $display("[TB] single out d=%0d ph=%0d last=%b", out_data, out_phase, out_last);
      tests++; if (out_valid !== 1'b1 || out_data !== e) begin fails++; $display("FAIL single_data%0d got v=%b d=%0h exp v=1 d=%0h", i, out_valid, out_data, e); end
      tests++; if (out_phase !== 2'(i) || out_last !== (i == 2)) begin fails++; $display("FAIL single_phase%0d got %0d/%b exp %0d/%b", i, out_phase, out_last, i, (i == 2)); end
      tick();
    end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int blk = 0, outn = 0, drops = 0, cyc = 0;
    bit acc, xf;
    out_ready = 1'b1;
    while (outn < 99 && cyc < 400) begin
      in_valid = (blk < 33);
      set_block(3 * blk + 1, 3 * blk + 2, 3 * blk + 3);
      #1;
      acc = in_valid && in_ready;
      xf  = out_valid && out_ready;
      if (blk < 33 && !in_ready) drops++;
      if (xf) begin
        $display("[TB] stream out d=%0d ph=%0d last=%b", out_data, out_phase, out_last);
        tests++;
        if (out_data !== DW'(outn + 1) || out_phase !== 2'(outn % 3) || out_last !== (outn % 3 == 2)) begin
          fails++;
          $display("FAIL stream_sample%0d got d=%0d ph=%0d last=%b exp d=%0d ph=%0d", outn, out_data, out_phase, out_last, outn + 1, outn % 3);
        end
      end
      tick();
      if (acc) blk++;
      if (xf) outn++;
      cyc++;
    end
    in_valid = 1'b0;
    tests++; if (outn != 99 || blk != 33) begin fails++; $display("FAIL stream_count got out=%0d blk=%0d exp 99/33", outn, blk); end
    tests++; if (drops == 0) begin fails++; $display("FAIL stream_ready_drop got %0d drops exp >0", drops); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stream_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_backpressure();
    int exp_rdy [4] = '{0, 0, 0, 1};
    int exp_d   [4] = '{10, 11, 12, 20};
    int tail    [5] = '{21, 22, 30, 31, 32};
    out_ready = 1'b0; in_valid = 1'b1;
    set_block(10, 11, 12); #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_accept_a got %b exp 1", in_ready); end
    tick();
    set_block(20, 21, 22); #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_accept_b got %b exp 1", in_ready); end
    tick();
    set_block(30, 31, 32); #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_full got %b exp 0", in_ready); end
    tick();
    tests++; if (in_ready !== 1'b0 || out_data !== DW'(10) || out_phase !== 2'd0) begin fails++; $display("FAIL bp_hold got rdy=%b d=%0d ph=%0d exp 0/10/0", in_ready, out_data, out_phase); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      $display("[TB] bp out d=%0d rdy=%b", out_data, in_ready);
      tests++; if (in_ready !== exp_rdy[i][0] || out_data !== DW'(exp_d[i])) begin fails++; $display("FAIL bp_release%0d got rdy=%b d=%0d exp rdy=%0d d=%0d", i, in_ready, out_data, exp_rdy[i], exp_d[i]); end
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      $display("[TB] bp out d=%0d", out_data);
      tests++; if (out_valid !== 1'b1 || out_data !== DW'(tail[i])) begin fails++; $display("FAIL bp_tail%0d got v=%b d=%0d exp v=1 d=%0d", i, out_valid, out_data, tail[i]); end
      tick();
    end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_negative_stall();
    logic [DW-1:0] e [3];
    int idx = 0, cyc = 0;
    bit xf;
    e[0] = 24'hFFFFFF; e[1] = 24'h800000; e[2] = 24'h7FFFFF;
    out_ready = 1'b0; in_valid = 1'b1;
    in_data1 = e[0]; in_data2 = e[1]; in_data3 = e[2];
    tick();
    in_valid = 1'b0;
    while (idx < 3 && cyc < 20) begin
      out_ready = (cyc % 2 == 1);
      #1;
      $display("[TB] neg out d=%0h ph=%0d rdy=%b", out_data, out_phase, out_ready);
      tests++; if (out_valid !== 1'b1 || out_data !== e[idx] || out_phase !== 2'(idx)) begin fails++; $display("FAIL neg_cyc%0d got v=%b d=%0h ph=%0d exp d=%0h ph=%0d", cyc, out_valid, out_data, out_phase, e[idx], idx); end
      xf = out_ready;
      tick();
      if (xf) idx++;
      cyc++;
    end
    out_ready = 1'b1;
    tests++; if (idx != 3 || out_valid !== 1'b0) begin fails++; $display("FAIL neg_done got idx=%0d v=%b exp 3/0", idx, out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1;
    set_block(40, 41, 42); tick();
    set_block(50, 51, 52); tick();
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    tests++; if (out_data !== DW'(40)) begin fails++; $display("FAIL mid_s0 got %0d exp 40", out_data); end
    tick();
    tests++; if (out_data !== DW'(41)) begin fails++; $display("FAIL mid_s1 got %0d exp 41", out_data); end
    tick();
    reset = 1'b1;
    tick();
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== '0) begin fails++; $display("FAIL mid_reset got v=%b rdy=%b d=%0d exp 0/0/0", out_valid, in_ready, out_data); end
    reset = 1'b0; in_valid = 1'b1;
    set_block(70, 71, 72);
    #1;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL mid_release got v=%b rdy=%b exp 0/1", out_valid, in_ready); end
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      $display("[TB] mid out d=%0d", out_data);
      tests++; if (out_valid !== 1'b1 || out_data !== DW'(70 + i)) begin fails++; $display("FAIL mid_new%0d got v=%b d=%0d exp v=1 d=%0d", i, out_valid, out_data, 70 + i); end
      tick();
    end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_drain got %b exp 0", out_valid); end
  endtask

`ifdef FIR_SER_STALL_STATS_EN
  task automatic test_stall_stats();
    reset = 1'b1; in_valid = 1'b0; tick();
    reset = 1'b0; #1;
    tests++; if (stall_cnt !== 16'd0) begin fails++; $display("FAIL stall_init got %0d exp 0", stall_cnt); end
    out_ready = 1'b0; in_valid = 1'b1;
    set_block(1, 2, 3);
    tick(); tick();
    repeat (5) tick();
    in_valid = 1'b0; #1;
    $display("[TB] stall_cnt=%0d", stall_cnt);
    tests++; if (stall_cnt !== 16'd5) begin fails++; $display("FAIL stall_count got %0d exp 5", stall_cnt); end
    reset = 1'b1; tick();
    tests++; if (stall_cnt !== 16'd0) begin fails++; $display("FAIL stall_clear got %0d exp 0", stall_cnt); end
    reset = 1'b0; out_ready = 1'b1;
  endtask
`endif

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_block(0, 0, 0);
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_negative_stall();
    test_reset_mid();
`ifdef FIR_SER_STALL_STATS_EN
    test_stall_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
